// File: rtl/io_uart_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_uart_responder
// Purpose  : Memory-mapped IO target on the core's IO bus. Holds the LED
//            register, an 8N1 UART transmitter and an 8N1 UART receiver that
//            feeds a small RX FIFO. Reads are combinational, side-effect free.
// Ports    : clk, resetn (sync, active-low)
//            io_addr[31:0]  byte address, word address = io_addr[15:2]
//            io_wdata[31:0] write data, io_wr single-cycle write strobe
//            io_rdata[31:0] combinational read data
//            leds           LED register
//            uart_tx        serial out (idle high), uart_rx serial in (async)
// Register map (one-hot on word address):
//            wa[0] LED, wa[1] TXDATA, wa[2] STATUS, wa[3] RXDATA
// Revision : 1.0 - initial release
// ============================================================================
module io_uart_responder #(
  parameter int CLK_FREQ_HZ   = 10000000,
  parameter int BAUD_RATE     = 1000000,
  parameter int RX_FIFO_DEPTH = 4,
  parameter int LED_WIDTH     = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          io_addr,
  input  logic [31:0]          io_wdata,
  input  logic                 io_wr,
  output logic [31:0]          io_rdata,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 uart_tx,
  input  logic                 uart_rx
);

  localparam int c_CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int c_CW  = $clog2(c_CPB);
  localparam int c_AW  = $clog2(RX_FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_CPB - 1);
  localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_CPB / 2 - 1);
  localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(RX_FIFO_DEPTH);

  // Shared state encoding for both serial FSMs
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [13:0] w_wa;
  logic        w_sel_led, w_sel_tx, w_sel_st, w_sel_rx;
  assign w_wa      = io_addr[15:2];
  assign w_sel_led = w_wa[0];
  assign w_sel_tx  = w_wa[1];
  assign w_sel_st  = w_wa[2];
  assign w_sel_rx  = w_wa[3];

  logic w_unused;
  assign w_unused = ^{io_addr[31:16], io_addr[1:0], w_wa[13:4], io_wdata[31:8]};

  // STATUS write-1-to-clear: [0] rx_ovr, [1] tx_ovr, [2] rx_ferr
  logic [2:0] w_clr;
  assign w_clr = (io_wr && w_sel_st) ? io_wdata[3:1] : 3'b000;

  // --------------------------------------------------------------------------
  // LED register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn)                leds <= '0;
    else if (io_wr && w_sel_led) leds <= io_wdata[LED_WIDTH-1:0];
  end

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  logic [1:0]      r_tx_state;
  logic [c_CW-1:0] r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_data;
  logic            w_tx_busy, w_tx_last, w_tx_wr, w_tx_accept;

  assign w_tx_busy   = (r_tx_state != c_ST_IDLE);
  // Final clock of the stop bit: a write here starts the next frame seamlessly
  assign w_tx_last   = (r_tx_state == c_ST_STOP) && (r_tx_cnt == c_BIT_LAST);
  assign w_tx_wr     = io_wr && w_sel_tx;
  assign w_tx_accept = w_tx_wr && (!w_tx_busy || w_tx_last);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx_state <= c_ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_data  <= '0;
      uart_tx    <= 1'b1;
    end else if (w_tx_accept) begin
      r_tx_state <= c_ST_START;
      r_tx_cnt   <= '0;
      r_tx_data  <= io_wdata[7:0];
      uart_tx    <= 1'b0;
    end else begin
      case (r_tx_state)
        c_ST_START: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_state <= c_ST_DATA;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            uart_tx    <= r_tx_data[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + c_CW'(1);
          end
        end
        c_ST_DATA: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= c_ST_STOP;
              uart_tx    <= 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              uart_tx  <= r_tx_data[r_tx_bit + 3'd1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + c_CW'(1);
          end
        end
        c_ST_STOP: begin
          if (r_tx_cnt == c_BIT_LAST) r_tx_state <= c_ST_IDLE;
          else                        r_tx_cnt   <= r_tx_cnt + c_CW'(1);
        end
        default: r_tx_state <= c_ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Receiver (2-flop synchronizer plus a delayed copy for edge detection)
  // --------------------------------------------------------------------------
  logic            r_rx_s1, r_rx_s2, r_rx_prev;
  logic [1:0]      r_rx_state;
  logic [c_CW-1:0] r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            w_rx_stop_smp, w_rx_push_req, w_rx_ferr_set;

  assign w_rx_stop_smp = (r_rx_state == c_ST_STOP) && (r_rx_cnt == c_BIT_LAST);
  assign w_rx_push_req = w_rx_stop_smp && r_rx_s2;
  assign w_rx_ferr_set = w_rx_stop_smp && !r_rx_s2;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= c_ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        c_ST_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_state <= c_ST_START;
            r_rx_cnt   <= '0;
          end
        end
        c_ST_START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit
          if (r_rx_cnt == c_HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? c_ST_IDLE : c_ST_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + c_CW'(1);
          end
        end
        c_ST_DATA: begin
          if (r_rx_cnt == c_BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= c_ST_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + c_CW'(1);
          end
        end
        c_ST_STOP: begin
          if (r_rx_cnt == c_BIT_LAST) r_rx_state <= c_ST_IDLE;
          else                        r_rx_cnt   <= r_rx_cnt + c_CW'(1);
        end
        default: r_rx_state <= c_ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]      r_mem [RX_FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            w_empty, w_full, w_pop, w_push, w_rx_ovr_set;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_FULL);
  assign w_pop        = io_wr && w_sel_rx && !w_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign w_push       = w_rx_push_req && (!w_full || w_pop);
  assign w_rx_ovr_set = w_rx_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (c_AW + 1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (c_AW + 1)'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags: a set on the same edge as a clear wins
  // --------------------------------------------------------------------------
  logic r_rx_ovr, r_tx_ovr, r_rx_ferr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_ovr  <= 1'b0;
      r_tx_ovr  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      r_rx_ovr  <= w_rx_ovr_set              || (r_rx_ovr  && !w_clr[0]);
      r_tx_ovr  <= (w_tx_wr && !w_tx_accept) || (r_tx_ovr  && !w_clr[1]);
      r_rx_ferr <= w_rx_ferr_set             || (r_rx_ferr && !w_clr[2]);
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: OR of all selected registers
  // --------------------------------------------------------------------------
  always_comb begin
    io_rdata = '0;
    if (w_sel_led)
      io_rdata = io_rdata | {{(32 - LED_WIDTH){1'b0}}, leds};
    if (w_sel_st)
      io_rdata = io_rdata | {22'b0, w_tx_busy, 5'b0, r_rx_ferr, r_tx_ovr, r_rx_ovr, !w_empty};
    if (w_sel_rx && !w_empty)
      io_rdata = io_rdata | {24'b0, r_mem[r_rd_ptr]};
  end

endmodule
`default_nettype wire

// File: tb/tb_io_uart_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_io_uart_responder
// Purpose  : Directed self-checking bench for io_uart_responder with the
//            default 10 clocks per bit. Each task drives one scenario and
//            checks its own expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_uart_responder;

  localparam logic [31:0] c_A_LED = 32'h0040_0004;
  localparam logic [31:0] c_A_TX  = 32'h0040_0008;
  localparam logic [31:0] c_A_ST  = 32'h0040_0010;
  localparam logic [31:0] c_A_RX  = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic        io_wr = 1'b0;
  logic [31:0] io_rdata;
  logic [5:0]  leds;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  io_uart_responder dut (
    .clk      (clk),
    .resetn   (resetn),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wr    (io_wr),
    .io_rdata (io_rdata),
    .leds     (leds),
    .uart_tx  (uart_tx),
    .uart_rx  (uart_rx)
  );

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; io_addr = '0; io_wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    io_addr = a;
    #1;
    d = io_rdata;
  endtask

  // 8N1 frame, 10 clocks per bit, transitions on falling clock edges
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rx = stop;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [31:0] d;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (leds !== 6'h00) begin n_fail++; $display("FAIL reset_leds: got %h want 00", leds); end
    n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    resetn = 1'b1;
    @(negedge clk);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
    bus_read(c_A_RX, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rxdata: got %h want 0", d); end
  endtask

  task automatic test_led;
    logic [31:0] d;
    bus_write(c_A_LED, 32'hFFFF_FF2A);
    n_tests++; if (leds !== 6'h2A) begin n_fail++; $display("FAIL led_write: got %h want 2a", leds); end
    bus_read(c_A_LED, d);
    n_tests++; if (d !== 32'h2A) begin n_fail++; $display("FAIL led_read: got %h want 2a", d); end
    bus_read(32'h0040_0014, d); // LED and STATUS selected together
    n_tests++; if (d !== 32'h2A) begin n_fail++; $display("FAIL led_status_or: got %h want 2a", d); end
    bus_read(32'h0040_0040, d); // no register selected
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL no_select: got %h want 0", d); end
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    n_tests++; if (leds !== 6'h00) begin n_fail++; $display("FAIL led_reset: got %h want 00", leds); end
  endtask

  task automatic test_tx;
    logic [31:0] d;
    logic [7:0]  b;
    logic        exp_tx;
    b = 8'h55;
    @(negedge clk);
    io_addr = c_A_TX; io_wdata = 32'h55; io_wr = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);       // i clocks after the accepting edge
      io_wr = 1'b0;
      exp_tx = (i < 10) ? 1'b0 : (i < 90) ? b[(i - 10) / 10] : 1'b1;
      n_tests++; if (uart_tx !== exp_tx) begin n_fail++; $display("FAIL tx_bit@%0d: got %b want %b", i, uart_tx, exp_tx); end
      bus_read(c_A_ST, d);
      if (i < 100) begin
        n_tests++; if (d[9] !== 1'b1) begin n_fail++; $display("FAIL tx_busy@%0d: got %b want 1", i, d[9]); end
      end else begin
        n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL tx_done_status: got %h want 4", d); end
      end
      if (i == 50) begin
        n_tests++; if (d !== 32'h204) begin n_fail++; $display("FAIL tx_ovr_status: got %h want 204", d); end
      end
      if (i == 49) begin io_addr = c_A_TX; io_wdata = 32'hAA; io_wr = 1'b1; end
    end
    bus_write(c_A_ST, 32'h4);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL tx_ovr_clear: got %h want 0", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    @(negedge clk);
    io_addr = c_A_TX; io_wdata = 32'h00; io_wr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      io_wr = 1'b0;
      if (i == 99) begin io_addr = c_A_TX; io_wdata = 32'hFF; io_wr = 1'b1; end
    end
    @(negedge clk);         // 100 clocks after the first accept
    io_wr = 1'b0;
    n_tests++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL b2b_start: got %b want 0", uart_tx); end
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h200) begin n_fail++; $display("FAIL b2b_status: got %h want 200", d); end
    repeat (50) @(negedge clk);
    n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL b2b_data: got %b want 1", uart_tx); end
    repeat (50) @(negedge clk);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL b2b_idle: got %h want 0", d); end
  endtask

  task automatic test_reset_mid_tx;
    logic [31:0] d;
    bus_write(c_A_TX, 32'h00);
    repeat (20) @(negedge clk);
    n_tests++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL midtx_low: got %b want 0", uart_tx); end
    resetn = 1'b0;
    @(negedge clk);
    n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL midtx_reset: got %b want 1", uart_tx); end
    resetn = 1'b1;
    @(negedge clk);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL midtx_status: got %h want 0", d); end
  endtask

  task automatic test_rx;
    logic [31:0] d;
    send_byte(8'hA3, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL rx_valid: got %h want 1", d); end
    bus_read(c_A_RX, d);
    n_tests++; if (d !== 32'hA3) begin n_fail++; $display("FAIL rx_data: got %h want a3", d); end
    bus_write(c_A_RX, 32'h0);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_popped_status: got %h want 0", d); end
    bus_read(c_A_RX, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_popped_data: got %h want 0", d); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1);
    repeat (2) @(negedge clk);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL ovr_status: got %h want 3", d); end
    for (int k = 1; k <= 4; k++) begin
      bus_read(c_A_RX, d);
      n_tests++; if (d !== 32'(k)) begin n_fail++; $display("FAIL ovr_pop%0d: got %h want %h", k, d, k); end
      bus_write(c_A_RX, 32'h0);
    end
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL ovr_empty: got %h want 2", d); end
    bus_write(c_A_ST, 32'h2);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL ovr_clear: got %h want 0", d); end
  endtask

  task automatic test_framing_glitch;
    logic [31:0] d;
    send_byte(8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h8) begin n_fail++; $display("FAIL ferr_status: got %h want 8", d); end
    bus_read(c_A_RX, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL ferr_rxdata: got %h want 0", d); end
    bus_write(c_A_ST, 32'h8);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL ferr_clear: got %h want 0", d); end
    @(negedge clk); uart_rx = 1'b0;
    repeat (2) @(negedge clk); uart_rx = 1'b1;
    repeat (120) @(negedge clk);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_status: got %h want 0", d); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    for (int k = 0; k < 4; k++) send_byte(8'h11 + 8'(k), 1'b1);
    // Fifth byte: pop lands on the stop-sample edge, 98 rising edges after the start bit
    fork
      send_byte(8'h15, 1'b1);
      begin
        @(negedge clk);
        repeat (97) @(posedge clk);
        @(negedge clk);
        io_addr = c_A_RX; io_wdata = 32'h0; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL simul_status: got %h want 1", d); end
    for (int k = 0; k < 4; k++) begin
      bus_read(c_A_RX, d);
      n_tests++; if (d !== 32'h12 + 32'(k)) begin n_fail++; $display("FAIL simul_pop%0d: got %h want %h", k, d, 32'h12 + 32'(k)); end
      bus_write(c_A_RX, 32'h0);
    end
    bus_read(c_A_ST, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL simul_empty: got %h want 0", d); end
  endtask

  initial begin
    test_reset;
    test_led;
    test_tx;
    test_back_to_back;
    test_reset_mid_tx;
    test_rx;
    test_overrun;
    test_framing_glitch;
    test_simultaneous;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
